// File: rtl/vram_pkg.sv
// Shared types and defaults for the character VRAM arbiter.
package vram_pkg;

    localparam int VRAM_ADDR_W = 11;
    localparam int VRAM_DATA_W = 8;
    localparam logic [7:0] VRAM_CLEAR_CHAR = 8'h20;

    // Screen-clear sequencer states.
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } clr_state_e;

    // Which requester owns the RAM port this cycle.
    typedef enum logic [1:0] {
        GNT_NONE  = 2'd0,
        GNT_DISP  = 2'd1,
        GNT_CLEAR = 2'd2,
        GNT_HOST  = 2'd3
    } gnt_src_e;

    // Host FIFO entry layout, MSB to LSB: {we, addr[addr_w], wdata[data_w]}.
    function automatic int entry_width(input int addr_w, input int data_w);
        return 1 + addr_w + data_w;
    endfunction

    function automatic int entry_we_pos(input int addr_w, input int data_w);
        return addr_w + data_w;
    endfunction

    function automatic int entry_addr_lsb(input int data_w);
        return data_w;
    endfunction

endpackage

// File: rtl/vram_host_fifo.sv
// Small synchronous FIFO for queued host operations, first-word head view.
module vram_host_fifo #(
    parameter int WIDTH      = 20,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0] PTR_ONE = (PTR_W + 1)'(1);

    // Pointers carry one extra wrap bit to tell full from empty.
    logic [PTR_W:0]   wptr_q, rptr_q;
    logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic             do_push, do_pop;

    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[PTR_W] != rptr_q[PTR_W]) &&
                     (wptr_q[PTR_W-1:0] == rptr_q[PTR_W-1:0]);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign head_o  = mem_q[rptr_q[PTR_W-1:0]];

    // Pointer update; push when full and pop when empty are dropped.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + PTR_ONE;
            if (do_pop)  rptr_q <= rptr_q + PTR_ONE;
        end
    end

    // Entry storage; contents are don't-care until pushed, so no reset.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wptr_q[PTR_W-1:0]] <= data_i;
    end

endmodule

// File: rtl/vram_arbiter.sv
// Single-port character VRAM arbiter: display fetch > screen clear > host FIFO.
//
//  state    | meaning
//  ---------+-----------------------------------------------------------
//  ST_IDLE  | no clear running; host FIFO drains into free slots
//  ST_CLEAR | writing CLEAR_CHAR to cells 0..VRAM_DEPTH-1 in free slots
module vram_arbiter
    import vram_pkg::*;
#(
    parameter int                 ADDR_W     = VRAM_ADDR_W,
    parameter int                 DATA_W     = VRAM_DATA_W,
    parameter int                 VRAM_DEPTH = 1200,
    parameter logic [DATA_W-1:0]  CLEAR_CHAR = DATA_W'(VRAM_CLEAR_CHAR),
    parameter int                 FIFO_DEPTH = 4
) (
    input  logic              i_pix_clk,
    input  logic              i_reset_n,
    input  logic              i_disp_req,
    input  logic [ADDR_W-1:0] i_disp_addr,
    output logic              o_disp_valid,
    output logic [DATA_W-1:0] o_disp_data,
    input  logic              i_host_valid,
    output logic              o_host_ready,
    input  logic              i_host_we,
    input  logic [ADDR_W-1:0] i_host_addr,
    input  logic [DATA_W-1:0] i_host_wdata,
    output logic              o_host_rvalid,
    output logic [DATA_W-1:0] o_host_rdata,
    input  logic              i_clear,
    output logic              o_busy,
    output logic              o_clear_done,
    output logic [ADDR_W-1:0] o_ram_addr,
    output logic              o_ram_we,
    output logic [DATA_W-1:0] o_ram_wdata,
    input  logic [DATA_W-1:0] i_ram_rdata
);

    localparam int ENTRY_W  = entry_width(ADDR_W, DATA_W);
    localparam int WE_POS   = entry_we_pos(ADDR_W, DATA_W);
    localparam int ADDR_LSB = entry_addr_lsb(DATA_W);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(VRAM_DEPTH - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

    clr_state_e        state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              done_q, done_d;
    gnt_src_e          gnt;

    logic               fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic [ENTRY_W-1:0] fifo_wdata, fifo_head;
    logic               head_we;
    logic [ADDR_W-1:0]  head_addr;
    logic [DATA_W-1:0]  head_wdata;

    logic              disp_p1_q, disp_valid_q;
    logic [DATA_W-1:0] disp_data_q;
    logic              host_p1_q, host_rvalid_q;
    logic [DATA_W-1:0] host_rdata_q;

    assign fifo_wdata = {i_host_we, i_host_addr, i_host_wdata};
    assign fifo_push  = i_host_valid && !fifo_full;
    assign fifo_pop   = (gnt == GNT_HOST);
    assign head_we    = fifo_head[WE_POS];
    assign head_addr  = fifo_head[ADDR_LSB +: ADDR_W];
    assign head_wdata = fifo_head[DATA_W-1:0];

    vram_host_fifo #(
        .WIDTH      (ENTRY_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_host_fifo (
        .clk_i   (i_pix_clk),
        .rst_ni  (i_reset_n),
        .push_i  (fifo_push),
        .data_i  (fifo_wdata),
        .pop_i   (fifo_pop),
        .head_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Fixed-priority grant; the host only drains while no clear is running.
    always_comb begin
        gnt = GNT_NONE;
        if (i_disp_req) begin
            gnt = GNT_DISP;
        end else if (state_q == ST_CLEAR) begin
            gnt = GNT_CLEAR;
        end else if (!fifo_empty) begin
            gnt = GNT_HOST;
        end
    end

    // RAM port mux of the granted source; idle cycles drive all zeros.
    always_comb begin
        o_ram_addr  = '0;
        o_ram_we    = 1'b0;
        o_ram_wdata = '0;
        unique case (gnt)
            GNT_DISP: begin
                o_ram_addr = i_disp_addr;
            end
            GNT_CLEAR: begin
                o_ram_addr  = cnt_q;
                o_ram_we    = 1'b1;
                o_ram_wdata = CLEAR_CHAR;
            end
            GNT_HOST: begin
                o_ram_addr  = head_addr;
                o_ram_we    = head_we;
                o_ram_wdata = head_we ? head_wdata : '0;
            end
            default: ;
        endcase
    end

    // Clear sequencer next state; the counter only advances on a granted slot.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (i_clear) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                end
            end
            ST_CLEAR: begin
                if (gnt == GNT_CLEAR) begin
                    if (cnt_q == LAST_ADDR) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + ADDR_ONE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Clear sequencer registers.
    always_ff @(posedge i_pix_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    // Read return: RAM data arrives the cycle after the grant and is registered
    // into the requester's output one cycle later, giving a fixed 2-cycle latency.
    always_ff @(posedge i_pix_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            disp_p1_q     <= 1'b0;
            disp_valid_q  <= 1'b0;
            disp_data_q   <= '0;
            host_p1_q     <= 1'b0;
            host_rvalid_q <= 1'b0;
            host_rdata_q  <= '0;
        end else begin
            disp_p1_q     <= (gnt == GNT_DISP);
            disp_valid_q  <= disp_p1_q;
            host_p1_q     <= (gnt == GNT_HOST) && !head_we;
            host_rvalid_q <= host_p1_q;
            if (disp_p1_q) disp_data_q  <= i_ram_rdata;
            if (host_p1_q) host_rdata_q <= i_ram_rdata;
        end
    end

    assign o_disp_valid  = disp_valid_q;
    assign o_disp_data   = disp_data_q;
    assign o_host_rvalid = host_rvalid_q;
    assign o_host_rdata  = host_rdata_q;
    assign o_host_ready  = !fifo_full;
    assign o_busy        = (state_q == ST_CLEAR);
    assign o_clear_done  = done_q;

endmodule
